// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: frames on vsync/href, assembles byte pairs into RGB565
// words for the pixel FIFO, skips settling frames and flags overflow/geometry errors.
module ov7670_capture #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SKIP_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   input  logic        full_fifo,
   input  logic        err_clr,
   output logic [15:0] dout,
   output logic        wr_en,
   output logic        frame_done,
   output logic        capturing,
   output logic        overflow,
   output logic        size_err,
   output logic [15:0] drop_cnt
);

   typedef enum logic [1:0] { SYNC, SKIP, CAPTURE, WAIT_VS } state_t;

   logic        vsync_q, href_q, vsync_prev_q, href_prev_q;
   logic [7:0]  data_q;
   state_t      state_q, state_d;
   logic [3:0]  skip_cnt_q, skip_cnt_d;
   logic [11:0] x_cnt_q, x_cnt_d;
   logic [11:0] line_cnt_q, line_cnt_d;
   logic        byte_ph_q, byte_ph_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] dout_q, dout_d;
   logic        pix_valid_q, pix_valid_d;
   logic        frame_done_q, frame_done_d;
   logic        capturing_q, capturing_d;
   logic        overflow_q, overflow_d;
   logic        size_err_q, size_err_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        start_frame;

   logic vs_fall, vs_rise, href_fall;
   assign vs_fall   = vsync_prev_q & ~vsync_q;
   assign vs_rise   = ~vsync_prev_q & vsync_q;
   assign href_fall = href_prev_q & ~href_q;

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      skip_cnt_d   = skip_cnt_q;
      x_cnt_d      = x_cnt_q;
      line_cnt_d   = line_cnt_q;
      byte_ph_d    = byte_ph_q;
      hi_d         = hi_q;
      dout_d       = dout_q;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      capturing_d  = (state_q == CAPTURE);
      overflow_d   = overflow_q;
      size_err_d   = size_err_q;
      drop_cnt_d   = drop_cnt_q;
      start_frame  = 1'b0;

      // Clear first so a simultaneous new error or drop wins.
      if (err_clr) begin
         overflow_d = 1'b0;
         size_err_d = 1'b0;
         drop_cnt_d = '0;
      end
      if (pix_valid_q && full_fifo) begin
         overflow_d = 1'b1;
         if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
      end

      case (state_q)
         SYNC: begin
            if (vs_fall) begin
               if (SKIP_FRAMES == 0) begin
                  start_frame = 1'b1;
               end else begin
                  skip_cnt_d = 4'd1;
                  state_d    = SKIP;
               end
            end
         end
         SKIP: begin
            // skip_cnt counts frames already discarded; the edge after the last one starts capture.
            if (vs_fall) begin
               if (skip_cnt_q >= 4'(SKIP_FRAMES)) start_frame = 1'b1;
               else                                skip_cnt_d  = skip_cnt_q + 4'd1;
            end
         end
         CAPTURE: begin
            if (href_q && !vsync_q) begin
               byte_ph_d = ~byte_ph_q;
               if (!byte_ph_q) begin
                  hi_d = data_q;
               end else begin
                  dout_d      = {hi_q, data_q};
                  pix_valid_d = 1'b1;
                  if (x_cnt_q != 12'hFFF) x_cnt_d = x_cnt_q + 12'd1;
               end
            end
            if (href_fall) begin
               if (x_cnt_q != 12'(H_ACTIVE) || byte_ph_q) size_err_d = 1'b1;
               if (line_cnt_q != 12'hFFF) line_cnt_d = line_cnt_q + 12'd1;
               x_cnt_d   = '0;
               byte_ph_d = 1'b0;
            end
            if (vs_rise) begin
               frame_done_d = 1'b1;
               if (line_cnt_d != 12'(V_ACTIVE)) size_err_d = 1'b1;
               state_d = WAIT_VS;
            end
         end
         WAIT_VS: begin
            if (vs_fall) start_frame = 1'b1;
         end
         default: state_d = SYNC;
      endcase

      if (start_frame) begin
         state_d    = CAPTURE;
         x_cnt_d    = '0;
         line_cnt_d = '0;
         byte_ph_d  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         data_q       <= '0;
         vsync_prev_q <= 1'b0;
         href_prev_q  <= 1'b0;
         state_q      <= SYNC;
         skip_cnt_q   <= '0;
         x_cnt_q      <= '0;
         line_cnt_q   <= '0;
         byte_ph_q    <= 1'b0;
         hi_q         <= '0;
         dout_q       <= '0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         capturing_q  <= 1'b0;
         overflow_q   <= 1'b0;
         size_err_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         vsync_q      <= cam_vsync;
         href_q       <= cam_href;
         data_q       <= cam_data;
         vsync_prev_q <= vsync_q;
         href_prev_q  <= href_q;
         state_q      <= state_d;
         skip_cnt_q   <= skip_cnt_d;
         x_cnt_q      <= x_cnt_d;
         line_cnt_q   <= line_cnt_d;
         byte_ph_q    <= byte_ph_d;
         hi_q         <= hi_d;
         dout_q       <= dout_d;
         pix_valid_q  <= pix_valid_d;
         frame_done_q <= frame_done_d;
         capturing_q  <= capturing_d;
         overflow_q   <= overflow_d;
         size_err_q   <= size_err_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign dout       = dout_q;
   assign wr_en      = pix_valid_q & ~full_fifo;
   assign frame_done = frame_done_q;
   assign capturing  = capturing_q;
   assign overflow   = overflow_q;
   assign size_err   = size_err_q;
   assign drop_cnt   = drop_cnt_q;

endmodule
